// File: rtl/otter_io_pkg.sv
// Shared constants for the OTTER memory-mapped UART transmitter:
// register offsets, STATUS bit positions and transmitter FSM states.
package otter_io_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/iobus_uart_tx_if.sv
// MCU IO-bus connection of the UART transmitter: address, write data,
// write strobe and the read-data return path.
interface iobus_uart_tx_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_rd_data;

  modport master (
    output iobus_addr,
    output iobus_out,
    output iobus_wr,
    input  iobus_rd_data
  );

  modport slave (
    input  iobus_addr,
    input  iobus_out,
    input  iobus_wr,
    output iobus_rd_data
  );
endinterface

// File: rtl/io_fifo.sv
// Small synchronous FIFO with combinational head read so a pop can load
// the consumer at the same edge; a push into a full FIFO is taken only with a pop.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic             pop_ok;
  logic             push_ok;

  assign full   = (count_reg == (AW+1)'(DEPTH));
  assign empty  = (count_reg == '0);
  assign count  = count_reg;
  assign dout   = mem[rd_ptr_reg];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
    if (push_ok && !pop_ok)      count_next = count_reg + 1'b1;
    else if (pop_ok && !push_ok) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes bytes into a FIFO,
// STATUS reports FIFO/FSM state and a sticky overflow flag.
module iobus_uart_tx
  import otter_io_pkg::*;
#(
  parameter int          CLK_FREQ   = 100_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0400
) (
  input  logic              clk,
  input  logic              rst_n,
  iobus_uart_tx_if.slave    bus,
  output logic              tx,
  output logic              irq
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FAW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = S_IDLE;
  localparam logic [1:0] START = S_START;
  localparam logic [1:0] DATA  = S_DATA;
  localparam logic [1:0] STOP  = S_STOP;

  generate
    if (DIV < 2) begin : g_div_check
      $error("iobus_uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (1 << FAW) != FIFO_DEPTH) begin : g_depth_check
      $error("iobus_uart_tx: FIFO_DEPTH must be a power of two in 2..256");
    end
  endgenerate

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          ovf_reg, ovf_next;

  logic          sel_txdata;
  logic          sel_status;
  logic          wr_txdata;
  logic          wr_status;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FAW:0]  fifo_count;
  logic          baud_done;
  logic [15:0]   count_ext;
  logic [31:0]   status_word;
  logic          unused_wdata;

  assign sel_txdata = (bus.iobus_addr == BASE_ADDR + TXDATA_OFS);
  assign sel_status = (bus.iobus_addr == BASE_ADDR + STATUS_OFS);
  assign wr_txdata  = bus.iobus_wr && sel_txdata;
  assign wr_status  = bus.iobus_wr && sel_status;
  assign unused_wdata = ^bus.iobus_out[31:8];

  io_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (bus.iobus_out[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_done = (baud_cnt_reg == CW'(DIV - 1));

  // tx_next is the line level for the cycle after this edge, so TX is a
  // clean register output and START drives low from the popping edge.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    fifo_pop      = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next       = 1'b1;
        baud_cnt_next = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_dout;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = DATA;
          tx_next       = shift_reg[0];
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          if (bit_cnt_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            shift_next   = {1'b0, shift_reg[7:1]};
            tx_next      = shift_reg[1];
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      default: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_dout;
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
    endcase
  end

  // Overflow set takes priority over a same-edge clear.
  always_comb begin
    ovf_next = ovf_reg;
    if (wr_status) ovf_next = 1'b0;
    if (wr_txdata && fifo_full && !fifo_pop) ovf_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign count_ext = 16'(fifo_count);

  always_comb begin
    status_word                          = '0;
    status_word[STAT_FULL]               = fifo_full;
    status_word[STAT_EMPTY]              = fifo_empty;
    status_word[STAT_BUSY]               = (state_reg != IDLE);
    status_word[STAT_OVF]                = ovf_reg;
    status_word[STAT_CNT_LSB +: 8]       = count_ext[7:0];
  end

  assign bus.iobus_rd_data = sel_status ? status_word : 32'h0;
  assign tx  = tx_reg;
  assign irq = fifo_empty && (state_reg == IDLE);

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Directed bench for iobus_uart_tx at DIV=10, FIFO_DEPTH=4: frame timing,
// back-to-back frames, overflow, mid-frame reset and read decode.
module tb_iobus_uart_tx;

  localparam logic [31:0] BASE   = 32'h1100_0400;
  localparam logic [31:0] TXDATA = BASE;
  localparam logic [31:0] STATUS = BASE + 32'h4;

  logic clk;
  logic rst_n;
  logic tx;
  logic irq;
  int   total = 0;
  int   bad   = 0;

  iobus_uart_tx_if bus ();

  iobus_uart_tx #(
    .CLK_FREQ   (100_000_000),
    .BAUD       (10_000_000),
    .FIFO_DEPTH (4),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tx    (tx),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller must be just past the edge at which the start bit begins.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk($sformatf("%s_bit%0d_cyc%0d", tag, k, c), {31'h0, tx}, {31'h0, frame[k]});
        if (k == 0 && c == 0) chk($sformatf("%s_irq_busy", tag), {31'h0, irq}, 32'h0);
      end
    end
  endtask

  initial begin
    int cyc;
    bus.iobus_addr = 32'h0;
    bus.iobus_out  = 32'h0;
    bus.iobus_wr   = 1'b0;
    rst_n          = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_irq", {31'h0, irq}, 32'h1);
    bus.iobus_addr = STATUS;
    #1 chk("rst_status", bus.iobus_rd_data, 32'h0000_0002);

    // Release reset and write at the very first edge after release; upper bits ignored
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.iobus_addr = TXDATA;
    bus.iobus_out  = 32'hFFFF_FF55;
    bus.iobus_wr   = 1'b1;
    @(posedge clk);
    #1 bus.iobus_wr = 1'b0;
    @(posedge clk);
    check_frame("f55", 8'h55);
    @(negedge clk);
    chk("f55_irq_done", {31'h0, irq}, 32'h1);

    // Two consecutive writes give two contiguous frames
    @(posedge clk);
    #1 bus.iobus_addr = TXDATA;
    bus.iobus_out = 32'h0000_00A5;
    bus.iobus_wr  = 1'b1;
    @(posedge clk);
    #1 bus.iobus_out = 32'h0000_003C;
    @(posedge clk);
    #1 bus.iobus_wr = 1'b0;
    check_frame("fA5", 8'hA5);
    check_frame("f3C", 8'h3C);
    @(negedge clk);
    chk("f3C_irq_done", {31'h0, irq}, 32'h1);

    // Six back-to-back writes: one popped, four queued, sixth dropped
    @(posedge clk);
    #1 bus.iobus_addr = TXDATA;
    bus.iobus_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.iobus_out = 32'(i + 1);
      @(posedge clk);
      #1;
    end
    bus.iobus_wr   = 1'b0;
    bus.iobus_addr = STATUS;
    @(negedge clk);
    chk("ovf_status", bus.iobus_rd_data, 32'h0000_040D);
    bus.iobus_out = 32'hFFFF_FFFF;
    bus.iobus_wr  = 1'b1;
    @(posedge clk);
    #1 bus.iobus_wr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", bus.iobus_rd_data, 32'h0000_0405);
    cyc = 0;
    while (!irq && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_irq", {31'h0, irq}, 32'h1);
    chk("drain_status", bus.iobus_rd_data, 32'h0000_0002);

    // Reset in the middle of the data bits of 0x0F
    @(posedge clk);
    #1 bus.iobus_addr = TXDATA;
    bus.iobus_out = 32'h0000_000F;
    bus.iobus_wr  = 1'b1;
    @(posedge clk);
    #1 bus.iobus_wr = 1'b0;
    @(posedge clk);
    repeat (55) @(negedge clk);
    chk("pre_rst_tx_low", {31'h0, tx}, 32'h0);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_tx", {31'h0, tx}, 32'h1);
    chk("mid_rst_irq", {31'h0, irq}, 32'h1);
    bus.iobus_addr = STATUS;
    #1 chk("mid_rst_status", bus.iobus_rd_data, 32'h0000_0002);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", i), {31'h0, tx}, 32'h1);
    end
    chk("post_rst_status", bus.iobus_rd_data, 32'h0000_0002);

    // Read decode
    bus.iobus_addr = 32'h1100_0000;
    #1 chk("unmapped_rd", bus.iobus_rd_data, 32'h0);
    bus.iobus_addr = TXDATA;
    #1 chk("txdata_rd", bus.iobus_rd_data, 32'h0);
    bus.iobus_addr = BASE + 32'h8;
    #1 chk("above_status_rd", bus.iobus_rd_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
